// File: rtl/frame_deser_pkg.sv
// Shared width helpers for the frame deserializer slice.
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
package frame_deser_pkg;

    // Width needed to hold a word count from 0 up to and including length.
    function automatic int count_width(input int length);
        return $clog2(length + 1);
    endfunction

    // Width of a frame sum: one word plus enough headroom for length words.
    function automatic int sum_width(input int data_width, input int length);
        return data_width + $clog2(length);
    endfunction

endpackage

// File: rtl/frame_deser_if.sv
// Word-stream in / frame out bundle for frame_deser (m_sum only with FRAME_DESER_SUM_EN).
// Latency: n/a (wiring only).
// Backpressure: s_ready throttles the word stream, m_ready throttles frame pops.
interface frame_deser_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4
);
    import frame_deser_pkg::*;

    localparam int CW = count_width(LENGTH);

    // Word stream side
    logic                          s_valid;
    logic signed [DATA_WIDTH-1:0]  s_data;
    logic                          s_ready;
    logic                          flush;

    // Frame side
    logic                          m_valid;
    logic                          m_ready;
    logic signed [DATA_WIDTH-1:0]  m_data [0:LENGTH-1];
    logic [CW-1:0]                 m_count;

`ifdef FRAME_DESER_SUM_EN
    localparam int SW = sum_width(DATA_WIDTH, LENGTH);
    logic signed [SW-1:0]          m_sum;

    modport slave (
        input  s_valid, s_data, flush, m_ready,
        output s_ready, m_valid, m_data, m_count, m_sum
    );

    modport master (
        output s_valid, s_data, flush, m_ready,
        input  s_ready, m_valid, m_data, m_count, m_sum
    );
`else
    modport slave (
        input  s_valid, s_data, flush, m_ready,
        output s_ready, m_valid, m_data, m_count
    );

    modport master (
        output s_valid, s_data, flush, m_ready,
        input  s_ready, m_valid, m_data, m_count
    );
`endif

endinterface

// File: rtl/frame_deser_collect.sv
// Collect buffer: gathers words into a frame and decides when a full or flushed partial frame leaves.
// Latency: emit strobes are combinational from this cycle's beat and registered state.
// Backpressure: a partial flush waits for out_free; full frames rely on the top gating s_ready.
// Optional running sum built only with FRAME_DESER_SUM_EN.
module frame_deser_collect
    import frame_deser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4,
    localparam int CW        = count_width(LENGTH)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          beat,
    input  logic signed [DATA_WIDTH-1:0]  data,
    input  logic                          flush,
    input  logic                          out_free,
    output logic                          at_last,
    output logic                          frame_done,
    output logic                          partial_done,
    output logic signed [DATA_WIDTH-1:0]  emit_data [LENGTH],
    output logic [CW-1:0]                 emit_count
`ifdef FRAME_DESER_SUM_EN
    ,
    output logic signed [sum_width(DATA_WIDTH, LENGTH)-1:0] emit_sum
`endif
);

    localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

    logic [CW-1:0]                idx;
    logic                         flush_pend;
    logic signed [DATA_WIDTH-1:0] col      [LENGTH];
    logic signed [DATA_WIDTH-1:0] col_next [LENGTH];
    logic [CW-1:0]                fill;
    logic                         emit;

    assign at_last = (idx == LAST);

    // Write this cycle's word into its slot so an emit in the same cycle already includes it
    always_comb begin
        for (int i = 0; i < LENGTH; i++) begin
            col_next[i] = (beat && idx == CW'(i)) ? data : col[i];
        end
    end

    // Emit decision: a completing beat wins; otherwise a pending flush goes once the output is free
    always_comb begin
        fill         = idx + CW'(beat);
        frame_done   = beat && at_last;
        partial_done = !frame_done && flush_pend && out_free && (fill != '0);
        emit         = frame_done || partial_done;
        emit_count   = fill;
        // Slots beyond the fill level read as zero so a partial frame never carries stale words
        for (int i = 0; i < LENGTH; i++) begin
            emit_data[i] = (CW'(i) < fill) ? col_next[i] : '0;
        end
    end

    // Slot index, stored words and sticky flush request
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx        <= '0;
            flush_pend <= 1'b0;
            for (int i = 0; i < LENGTH; i++) begin
                col[i] <= '0;
            end
        end else begin
            idx <= emit ? '0 : fill;
            for (int i = 0; i < LENGTH; i++) begin
                col[i] <= col_next[i];
            end
            // A pending flush is consumed by any emit, and dropped when there is nothing to send;
            // a new flush request always re-arms it
            flush_pend <= flush || (flush_pend && !emit && (fill != '0));
        end
    end

`ifdef FRAME_DESER_SUM_EN
    localparam int SW = sum_width(DATA_WIDTH, LENGTH);

    logic signed [SW-1:0] acc;
    logic signed [SW-1:0] data_ext;
    logic signed [SW-1:0] sum_next;

    assign data_ext = {{(SW-DATA_WIDTH){data[DATA_WIDTH-1]}}, data};
    assign sum_next = beat ? (acc + data_ext) : acc;
    assign emit_sum = sum_next;

    // Running sum of the frame being collected; restarts whenever a frame leaves
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc <= '0;
        end else begin
            acc <= emit ? '0 : sum_next;
        end
    end
`endif

endmodule

// File: rtl/frame_deser.sv
// Serial-to-parallel frame deserializer: LENGTH signed words in, one parallel frame out.
// Latency: frame valid the cycle after its last word is accepted; flushed partial one cycle after flush.
// Backpressure: s_ready drops only when the output is still held and the collect buffer is on its last slot.
// FRAME_DESER_SUM_EN adds the m_sum frame-sum output.
module frame_deser
    import frame_deser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    frame_deser_if.slave  bus
);

    localparam int CW = count_width(LENGTH);

    logic                         beat;
    logic                         pop;
    logic                         out_free;
    logic                         at_last;
    logic                         frame_done;
    logic                         partial_done;
    logic signed [DATA_WIDTH-1:0] emit_data [LENGTH];
    logic [CW-1:0]                emit_count;

`ifdef FRAME_DESER_SUM_EN
    localparam int SW = sum_width(DATA_WIDTH, LENGTH);
    logic signed [SW-1:0]         emit_sum;
`endif

    // Registered-only ready: a full frame can never arrive while the output is occupied,
    // so a pop and a frame completion never have to be resolved in the same cycle
    assign bus.s_ready = reset_n && !(bus.m_valid && at_last);
    assign beat        = bus.s_valid && bus.s_ready;
    assign pop         = bus.m_valid && bus.m_ready;
    assign out_free    = !bus.m_valid || pop;

    frame_deser_collect #(
        .DATA_WIDTH (DATA_WIDTH),
        .LENGTH     (LENGTH)
    ) u_collect (
        .clk          (clk),
        .reset_n      (reset_n),
        .beat         (beat),
        .data         (bus.s_data),
        .flush        (bus.flush),
        .out_free     (out_free),
        .at_last      (at_last),
        .frame_done   (frame_done),
        .partial_done (partial_done),
        .emit_data    (emit_data),
        .emit_count   (emit_count)
`ifdef FRAME_DESER_SUM_EN
        ,
        .emit_sum     (emit_sum)
`endif
    );

    // Output frame register: loads on any emit (even while popping), otherwise holds; valid drops on pop
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.m_valid <= 1'b0;
            bus.m_count <= '0;
            for (int i = 0; i < LENGTH; i++) begin
                bus.m_data[i] <= '0;
            end
`ifdef FRAME_DESER_SUM_EN
            bus.m_sum   <= '0;
`endif
        end else if (frame_done || partial_done) begin
            bus.m_valid <= 1'b1;
            bus.m_count <= emit_count;
            for (int i = 0; i < LENGTH; i++) begin
                bus.m_data[i] <= emit_data[i];
            end
`ifdef FRAME_DESER_SUM_EN
            bus.m_sum   <= emit_sum;
`endif
        end else if (pop) begin
            bus.m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_deser.sv
// Bench for frame_deser with DATA_WIDTH=8, LENGTH=4; expected frames queued as words are driven.
// Latency: inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: m_ready driven per scenario; every pop is checked against the queue head.
module tb_frame_deser;

    localparam int DW  = 8;
    localparam int LEN = 4;

    typedef struct packed {
        logic [3:0][7:0] d;
        logic [2:0]      cnt;
        logic [9:0]      sum;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    exp_t sb [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    frame_deser_if #(.DATA_WIDTH(DW), .LENGTH(LEN)) bus ();

    frame_deser #(.DATA_WIDTH(DW), .LENGTH(LEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic exp_t mk(input int a, input int b, input int c, input int d, input int cnt);
        exp_t e;
        e.d[0] = 8'(a);
        e.d[1] = 8'(b);
        e.d[2] = 8'(c);
        e.d[3] = 8'(d);
        e.cnt  = 3'(cnt);
        e.sum  = 10'(a + b + c + d);
        return e;
    endfunction

    // One clock cycle; a frame popped in this cycle is compared with the scoreboard head
    task automatic tick(output bit acc, output bit pop);
        exp_t  e;
        bit    bad;
        string sum_s;
        @(negedge clk);
        acc = (bus.s_valid === 1'b1) && (bus.s_ready === 1'b1);
        pop = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b1);
        if (pop) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL frame_pop: unexpected frame cnt=%0d, required no frame", bus.m_count);
            end else begin
                e     = sb.pop_front();
                bad   = (bus.m_count !== e.cnt);
                sum_s = "";
                for (int i = 0; i < LEN; i++) bad |= (bus.m_data[i] !== e.d[i]);
`ifdef FRAME_DESER_SUM_EN
                bad  |= (bus.m_sum !== e.sum);
                sum_s = $sformatf(" sum=%0d/%0d", bus.m_sum, $signed(e.sum));
`endif
                if (bad) begin
                    n_fail++;
                    $display("FAIL frame_pop: got {%0d,%0d,%0d,%0d} cnt=%0d, required {%0d,%0d,%0d,%0d} cnt=%0d%s",
                             bus.m_data[0], bus.m_data[1], bus.m_data[2], bus.m_data[3], bus.m_count,
                             $signed(e.d[0]), $signed(e.d[1]), $signed(e.d[2]), $signed(e.d[3]), e.cnt, sum_s);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer words one at a time, holding each until it is accepted
    task automatic send_words(input int w [$], output int cyc);
        bit acc, pop;
        int n;
        cyc = 0;
        foreach (w[i]) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(w[i]);
            n = 0;
            do begin
                tick(acc, pop);
                n++;
                cyc++;
            end while (!acc && n < 50);
            if (!acc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: word %0d not accepted after %0d cycles, required acceptance", w[i], n);
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        bit a, p;
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick(a, p);
            n++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d frames outstanding after %0d cycles, required 0", sb.size(), n);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h55;
        bus.flush   = 1'b0;
        bus.m_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b, required 0", bus.s_ready); end
        n_cmp++;
        if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b, required 0", bus.m_valid); end
        n_cmp++;
        if (bus.m_count !== 3'd0) begin n_fail++; $display("FAIL reset_m_count: got %0d, required 0", bus.m_count); end
        n_cmp++;
        if (bus.m_data[0] !== 8'd0 || bus.m_data[1] !== 8'd0 || bus.m_data[2] !== 8'd0 || bus.m_data[3] !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_m_data: got {%0d,%0d,%0d,%0d}, required {0,0,0,0}",
                     bus.m_data[0], bus.m_data[1], bus.m_data[2], bus.m_data[3]);
        end
`ifdef FRAME_DESER_SUM_EN
        n_cmp++;
        if (bus.m_sum !== 10'd0) begin n_fail++; $display("FAIL reset_m_sum: got %0d, required 0", bus.m_sum); end
`endif
        bus.s_valid = 1'b0;
        reset_n     = 1'b1;
        #1;
        n_cmp++;
        if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL release_s_ready: got %b, required 1", bus.s_ready); end
    endtask

    task automatic test_full_frame();
        int c;
        bus.m_ready = 1'b1;
        sb.push_back(mk(1, 2, 3, 4, 4));
        send_words('{1, 2, 3, 4}, c);
        n_cmp++;
        if (c !== 4) begin n_fail++; $display("FAIL full_accept_cycles: got %0d, required 4", c); end
        n_cmp++;
        if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL full_m_valid: got %b, required 1", bus.m_valid); end
        drain(5);
    endtask

    task automatic test_back_to_back();
        int c;
        bus.m_ready = 1'b1;
        sb.push_back(mk(10, 11, 12, 13, 4));
        sb.push_back(mk(14, 15, 16, 17, 4));
        send_words('{10, 11, 12, 13, 14, 15, 16, 17}, c);
        n_cmp++;
        if (c !== 8) begin n_fail++; $display("FAIL b2b_accept_cycles: got %0d, required 8", c); end
        drain(5);
    endtask

    task automatic test_backpressure();
        bit acc, pop, moved;
        int w = 0;
        int n = 0;
        bus.m_ready = 1'b0;
        moved = 1'b0;
        sb.push_back(mk(5, 6, 7, 8, 4));
        sb.push_back(mk(9, 10, 11, 12, 4));
        for (int cyc = 0; cyc < 10; cyc++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(5 + w);
            tick(acc, pop);
            if (acc) w++;
            if (bus.m_valid === 1'b1 && (bus.m_data[0] !== 8'd5 || bus.m_data[3] !== 8'd8)) moved = 1'b1;
        end
        n_cmp++;
        if (w !== 7) begin n_fail++; $display("FAIL bp_accepted: got %0d words, required 7", w); end
        n_cmp++;
        if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready: got %b, required 0", bus.s_ready); end
        n_cmp++;
        if (moved || bus.m_valid !== 1'b1 || bus.m_data[1] !== 8'd6 || bus.m_data[2] !== 8'd7) begin
            n_fail++;
            $display("FAIL bp_hold: got valid=%b {%0d,%0d,%0d,%0d} changed=%b, required valid=1 {5,6,7,8} changed=0",
                     bus.m_valid, bus.m_data[0], bus.m_data[1], bus.m_data[2], bus.m_data[3], moved);
        end
        bus.m_ready = 1'b1;
        while ((w < 8 || sb.size() != 0) && n < 20) begin
            bus.s_valid = (w < 8);
            bus.s_data  = 8'(5 + w);
            tick(acc, pop);
            if (acc) w++;
            n++;
        end
        bus.s_valid = 1'b0;
        n_cmp++;
        if (w !== 8 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL bp_release: got %0d words, %0d frames left, required 8 words, 0 frames", w, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_flush();
        bit a, p, seen;
        int c;
        bus.m_ready = 1'b1;
        sb.push_back(mk(5, 6, 7, 0, 3));
        send_words('{5, 6, 7}, c);
        bus.flush = 1'b1;
        tick(a, p);
        bus.flush = 1'b0;
        n_cmp++;
        if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_early: got m_valid=%b, required 0", bus.m_valid); end
        tick(a, p);
        n_cmp++;
        if (bus.m_valid !== 1'b1 || bus.m_count !== 3'd3 || bus.m_data[3] !== 8'd0) begin
            n_fail++;
            $display("FAIL flush_emit: got valid=%b cnt=%0d slot3=%0d, required valid=1 cnt=3 slot3=0",
                     bus.m_valid, bus.m_count, bus.m_data[3]);
        end
        drain(3);
        // flush with nothing collected must produce no frame
        bus.flush = 1'b1;
        tick(a, p);
        bus.flush = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            tick(a, p);
            if (bus.m_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_fail++; $display("FAIL flush_empty: got m_valid=1, required 0"); end
    endtask

    task automatic test_flush_pop();
        bit a, p;
        int c;
        bus.m_ready = 1'b0;
        sb.push_back(mk(1, 2, 3, 4, 4));
        sb.push_back(mk(5, 6, 0, 0, 2));
        send_words('{1, 2, 3, 4, 5, 6}, c);
        bus.flush = 1'b1;
        tick(a, p);
        bus.flush = 1'b0;
        tick(a, p);
        n_cmp++;
        if (bus.m_valid !== 1'b1 || bus.m_count !== 3'd4) begin
            n_fail++;
            $display("FAIL flushpop_wait: got valid=%b cnt=%0d, required valid=1 cnt=4", bus.m_valid, bus.m_count);
        end
        bus.m_ready = 1'b1;
        tick(a, p);
        n_cmp++;
        if (bus.m_valid !== 1'b1 || bus.m_count !== 3'd2) begin
            n_fail++;
            $display("FAIL flushpop_reload: got valid=%b cnt=%0d, required valid=1 cnt=2", bus.m_valid, bus.m_count);
        end
        drain(3);
    endtask

    task automatic test_signed();
        int c;
        bus.m_ready = 1'b1;
        sb.push_back(mk(-1, -128, 127, 0, 4));
        send_words('{-1, -128, 127, 0}, c);
        drain(5);
    endtask

    task automatic test_reset_mid();
        bit a, p;
        int c;
        bus.m_ready = 1'b1;
        send_words('{77, 88}, c);
        reset_n = 1'b0;
        tick(a, p);
        reset_n = 1'b1;
        n_cmp++;
        if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_m_valid: got %b, required 0", bus.m_valid); end
        sb.push_back(mk(1, 2, 3, 4, 4));
        send_words('{1, 2, 3, 4}, c);
        drain(5);
        repeat (5) tick(a, p);
        n_cmp++;
        if (bus.m_count !== 3'd4) begin n_fail++; $display("FAIL midreset_hold_count: got %0d, required 4", bus.m_count); end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.flush   = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_flush_pop();
        test_signed();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/frame_deser.md
# frame_deser

Serial-to-parallel frame deserializer: the consuming end of the shift-register word stream. Accepts signed words one per beat over a valid/ready handshake and assembles them into frames of LENGTH words. Presents each frame as a parallel array with valid/ready on the output side. Separate collect and output buffers allow the next frame to fill while the previous one waits for the downstream consumer.

## Interface
- DATA_WIDTH, 8, width of one signed word
- LENGTH, 4, words per frame (≥2)
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- s_valid  in  1  input word valid
- s_data  in  DATA_WIDTH signed  input word
- s_ready  out  1  input can accept a word this cycle
- flush  in  1  one-cycle request to emit the partial frame
- m_valid  out  1  output frame valid
- m_ready  in  1  downstream accepts the frame
- m_data  out  DATA_WIDTH signed × [0:LENGTH-1] unpacked  frame words; first received word is in m_data[0]
- m_count  out  $clog2(LENGTH+1)  number of meaningful words in m_data
- m_sum  out  DATA_WIDTH+$clog2(LENGTH) signed  frame sum (present only with FRAME_DESER_SUM_EN)

## Operation
- Input beat accepted when s_valid && s_ready. Word is stored at col[idx], and idx is incremented.
- s_ready = reset_n && !(m_valid && idx == LENGTH-1). It is derived from registers and reset_n only, with no path from m_ready.
- When a beat with idx == LENGTH-1 is accepted, the full frame (including that word) moves to the output registers. Then m_valid←1, m_count←LENGTH, idx←0.
- Output pop when m_valid && m_ready: m_valid←0. m_data, m_count and m_sum keep their values until overwritten.
- m_data, m_count and m_sum are stable while m_valid=1 && !m_ready.
- flush sets a sticky flush_pend flag.
- flush_pend executes when idx>0 and output is free (m_valid==0, or a pop occurs this cycle):
  - partial frame moves out, with m_count←idx;
  - slots idx..LENGTH-1 of m_data are 0;
  - idx←0 and flush_pend←0.
- flush_pend with idx==0 is cleared with no output.
- Same-cycle accepted beat and flush_pend: the beat is stored first.
  - If that beat completes the frame, a normal full frame is emitted and flush_pend is cleared.
  - Otherwise the partial frame, including the new word, is emitted once output is free.
- Same-cycle pop and frame completion cannot occur, because s_ready is low in that state. Partial-flush and pop can coincide: the output reloads and m_valid stays 1.

## Timing
- Reset (reset_n low at an edge):
  - idx=0, flush_pend=0, m_valid=0;
  - m_data all 0, m_count=0, m_sum=0;
  - s_ready=0 while reset_n low, and 1 in the first cycle after release.
- Latency: m_valid rises at the edge that accepts the last word of a frame (visible the following cycle). Flush output appears at the edge after flush is sampled, if the output is free.
- Throughput: one word per cycle sustained when m_ready=1. With m_ready=1, a stall bubble occurs only if a frame is still unpopped when the next frame's last word arrives.
- Reset mid-frame discards the collected words and any held output frame.

## Configuration
- FRAME_DESER_SUM_EN defined:
  - m_sum port present;
  - running signed sum accumulated with each accepted beat, cleared at frame emit;
  - m_sum is loaded with the frame sum together with m_data;
  - sign extension is to DATA_WIDTH+$clog2(LENGTH), so the sum never overflows.
- FRAME_DESER_SUM_EN undefined: m_sum port and accumulator absent, and all other behaviour is identical.

## Structure
- Package frame_deser_pkg holds two helpers:
  - count-width function $clog2(LENGTH+1);
  - sum-width function DATA_WIDTH+$clog2(LENGTH).
- Sub-module frame_deser_collect: collect buffer col[], idx counter, flush_pend, and optional accumulator. It exposes a frame_done / partial_done strobe and the frame contents.
- The top level holds the output registers and the handshake logic.

## Test plan
All scenarios use DATA_WIDTH=8, LENGTH=4.
- Reset: hold reset_n=0 for 4 cycles with s_valid=1 → s_ready=0, m_valid=0, m_data={0,0,0,0}, m_count=0. After release → s_ready=1.
- Full frame: send 1,2,3,4 back-to-back with m_ready=1 → m_valid high one cycle after the 4th accept; m_data={1,2,3,4}, m_count=4, m_sum=10.
- Backpressure: m_ready=0, offer 5..12 continuously → frame {5,6,7,8} held stable; 9,10,11 accepted; s_ready=0 with 12 pending. Raise m_ready → pop, then 12 accepted, next frame {9,10,11,12}, m_sum=42.
- Flush: send 5,6,7, pulse flush → m_data={5,6,7,0}, m_count=3, m_sum=18. Flush with idx=0 → no m_valid.
- Signed: send -1,-128,127,0 → m_data={-1,-128,127,0}, m_sum=-2.
- Reset mid-frame: accept 2 words, reset 1 cycle, then send 1,2,3,4 → single frame {1,2,3,4}, m_count=4.
